// File: rtl/count_display_driver.sv
// Binary-to-BCD converter (serial double dabble) driving a multiplexed 7-segment display.
// Optional macro COUNT_DISP_BLANK_EN blanks leading zero digits above digit 0.

module count_display_driver_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module count_display_driver #(
  parameter int N           = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          count,
  input  logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            segments
);
  localparam int BW     = 4*DIGITS;
  localparam int ITER_W = $clog2(N);
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int d);
    longint unsigned r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAX_CNT = (64'd1 << N) - 64'd1;

  if (N < 4 || N > 20) begin : g_bad_n
    $error("count_display_driver: N must be 4..20");
  end
  if (pow10(DIGITS) <= MAX_CNT) begin : g_bad_digits
    $error("count_display_driver: DIGITS too small to hold 2^N-1");
  end
  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("count_display_driver: REFRESH_DIV must be >= 2");
  end

  typedef enum logic {IDLE, CONVERT} state_t;
  state_t state, state_nxt;

  logic [N-1:0]      work_bin, nxt_bin, start_val, pend_val;
  logic [BW-1:0]     work_bcd, nxt_bcd, adj;
  logic [ITER_W-1:0] iter;
  logic              pend_vld, start, last_iter;

  // One add-3 cell per BCD digit; the shift happens after adjustment.
  for (genvar i = 0; i < DIGITS; i++) begin : g_cell
    count_display_driver_add3 u_add3 (
      .d (work_bcd[4*i +: 4]),
      .q (adj[4*i +: 4])
    );
  end

  assign nxt_bcd   = BW'({adj, work_bin[N-1]});
  assign nxt_bin   = {work_bin[N-2:0], 1'b0};
  assign last_iter = (state == CONVERT) && (iter == ITER_W'(N-1));
  assign busy      = (state == CONVERT);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A fresh valid on the final edge is newer than anything pending, so it wins.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    start_val = count;
    case (state)
      IDLE: if (valid) begin
        start     = 1'b1;
        state_nxt = CONVERT;
      end
      CONVERT: if (last_iter) begin
        if (valid) begin
          start = 1'b1;
        end else if (pend_vld) begin
          start     = 1'b1;
          start_val = pend_val;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done     <= 1'b0;
      bcd      <= '0;
      pend_vld <= 1'b0;
      pend_val <= '0;
      work_bin <= '0;
      work_bcd <= '0;
      iter     <= '0;
    end else begin
      done <= last_iter;
      if (last_iter) bcd <= nxt_bcd;
      if (start) begin
        work_bin <= start_val;
        work_bcd <= '0;
        iter     <= '0;
      end else if (state == CONVERT) begin
        work_bin <= nxt_bin;
        work_bcd <= nxt_bcd;
        iter     <= iter + ITER_W'(1);
      end
      if (last_iter) begin
        pend_vld <= 1'b0;
      end else if (state == CONVERT && valid) begin
        pend_vld <= 1'b1;
        pend_val <= count;
      end
    end
  end

  // Display scan
  logic [REF_W-1:0]             refresh_cnt;
  logic [IDX_W-1:0]             idx;
  logic [DIGITS-1:0][3:0]       digs;
  logic [3:0]                   cur;
  logic [6:0]                   seg_dec;

  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == REF_W'(REFRESH_DIV-1)) begin
      refresh_cnt <= '0;
      idx         <= (idx == IDX_W'(DIGITS-1)) ? '0 : idx + IDX_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

  assign digs   = bcd;
  assign cur    = digs[idx];
  assign anodes = ~(DIGITS'(1) << idx);

  always_comb begin
    seg_dec = 7'b1111111;
    case (cur)
      4'd0: seg_dec = 7'b1000000;
      4'd1: seg_dec = 7'b1111001;
      4'd2: seg_dec = 7'b0100100;
      4'd3: seg_dec = 7'b0110000;
      4'd4: seg_dec = 7'b0011001;
      4'd5: seg_dec = 7'b0010010;
      4'd6: seg_dec = 7'b0000010;
      4'd7: seg_dec = 7'b1111000;
      4'd8: seg_dec = 7'b0000000;
      4'd9: seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

`ifdef COUNT_DISP_BLANK_EN
  logic [DIGITS-1:0] blank;
  assign blank[0] = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_blank
    assign blank[i] = (bcd[BW-1:4*i] == '0);
  end
  assign segments = blank[idx] ? 7'b1111111 : seg_dec;
`else
  assign segments = seg_dec;
`endif

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver (N=16, DIGITS=5, REFRESH_DIV=4).
module tb_count_display_driver;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] count;
  logic        valid;
  logic        busy, done;
  logic [19:0] bcd;
  logic [4:0]  anodes;
  logic [6:0]  segments;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [19:0] exp_q[$];
  logic [19:0] e;

`ifdef COUNT_DISP_BLANK_EN
  localparam logic [6:0] HI_SEG = 7'b1111111;
`else
  localparam logic [6:0] HI_SEG = 7'b1000000;
`endif
  localparam logic [4:0] AN_TAB [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
  localparam logic [6:0] SEG_TAB [5] = '{7'b0100100, 7'b0011001, HI_SEG, HI_SEG, HI_SEG};

  count_display_driver #(.N(16), .DIGITS(5), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .count(count), .valid(valid), .busy(busy),
    .done(done), .bcd(bcd), .anodes(anodes), .segments(segments)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("bcd_on_done", {12'h0, bcd}, {12'h0, e});
      end
    end
  end

  task automatic send(input logic [15:0] v);
    count = v;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_reached", {31'h0, busy | done}, 0);
  endtask

  initial begin
    int d0;
    int n;
    logic early;
    // reset with valid asserted: must be ignored
    reset = 1'b0; valid = 1'b1; count = 16'd777;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1; valid = 1'b0;
    @(negedge clk);
    chk("rst_bcd", {12'h0, bcd}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_anodes", {27'h0, anodes}, 32'b11110);
    chk("rst_segments", {25'h0, segments}, 32'b1000000);
    @(posedge clk); #1;

    // 1234: latency and busy timing
    exp_q.push_back(20'h01234);
    send(16'd1234);
    chk("busy_after_capture", {31'h0, busy}, 1);
    early = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) early = 1'b1;
    end
    chk("done_early", {31'h0, early}, 0);
    @(posedge clk); #1;
    chk("done_at_16", {31'h0, done}, 1);
    chk("busy_drop", {31'h0, busy}, 0);
    wait_idle();

    // extremes, bcd holds during conversion
    exp_q.push_back(20'h65535);
    send(16'd65535);
    wait_idle();
    exp_q.push_back(20'h00000);
    send(16'd0);
    repeat (5) @(posedge clk); #1;
    chk("bcd_hold", {12'h0, bcd}, 32'h65535);
    wait_idle();

    // pending: latest wins
    d0 = done_cnt;
    exp_q.push_back(20'h00200);
    exp_q.push_back(20'h00300);
    send(16'd200);
    repeat (3) @(posedge clk); #1;
    send(16'd100);
    repeat (2) @(posedge clk); #1;
    send(16'd300);
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("first_done_seen", {31'h0, done}, 1);
    chk("busy_through_restart", {31'h0, busy}, 1);
    @(posedge clk); #1;
    wait_idle();
    chk("two_done_pulses", done_cnt - d0, 2);

    // display scan of 42
    exp_q.push_back(20'h00042);
    send(16'd42);
    wait_idle();
    n = 0;
    @(negedge clk);
    while (anodes !== 5'b01111 && n < 30) begin @(negedge clk); n++; end
    while (anodes !== 5'b11110 && n < 40) begin @(negedge clk); n++; end
    chk("scan_sync", {27'h0, anodes}, 32'b11110);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("anodes_k%0d", k), {27'h0, anodes}, {27'h0, AN_TAB[k/4]});
      chk($sformatf("segments_k%0d", k), {25'h0, segments}, {25'h0, SEG_TAB[k/4]});
      @(negedge clk);
    end

    // reset mid-conversion of 999
    @(posedge clk); #1;
    d0 = done_cnt;
    send(16'd999);
    repeat (4) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_busy", {31'h0, busy}, 0);
    chk("abort_bcd", {12'h0, bcd}, 32'h0);
    chk("abort_done", {31'h0, done}, 0);
    repeat (20) @(posedge clk); #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_busy_late", {31'h0, busy}, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/count_display_driver.md
COUNT_DISPLAY_DRIVER -- requirements
Module: count_display_driver

Interface
REQ-001 Parameter N, default 16: width of the binary count consumed; SHALL be 4..20.
REQ-002 Parameter DIGITS, default 5: number of 7-segment digits driven; SHALL satisfy 10^DIGITS > 2^N-1, else elaboration SHALL fail via assertion.
REQ-003 Parameter REFRESH_DIV, default 100000: clk cycles per displayed digit; SHALL be >= 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-006 count  input  N  binary value from upstream counter.
REQ-007 valid  input  1  request to capture count this cycle.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when bcd is updated.
REQ-010 bcd  output  4*DIGITS  last converted value, digit i at bits [4i+3:4i], digit 0 least significant.
REQ-011 anodes  output  DIGITS  active-low digit select, exactly one bit low at any time.
REQ-012 segments  output  7  active-low segments, bit 0 = CA … bit 6 = CG.

Function
REQ-013 FSM states SHALL be IDLE and CONVERT; IDLE -> CONVERT on a capture, CONVERT -> IDLE after N iterations unless a pending request exists.
REQ-014 In IDLE with valid=1, count SHALL be captured at that edge; busy SHALL be 1 from the next cycle.
REQ-015 Conversion SHALL be shift-and-add-3 (double dabble), exactly one bit per cycle, N cycles.
REQ-016 On the N-th iteration edge, bcd SHALL load the result, done SHALL be 1 for exactly that following cycle, and busy SHALL drop unless a pending request restarts conversion.
REQ-017 valid=1 while busy SHALL store count in a one-entry pending register; later valid pulses overwrite it (latest wins).
REQ-018 With pending set at conversion end, the pending value SHALL be captured on the same edge done is raised; busy stays 1, pending clears.
REQ-019 bcd SHALL hold its value throughout conversion; the display SHALL never show partial results.
REQ-020 A refresh counter SHALL count 0..REFRESH_DIV-1; on wrap the digit index SHALL advance, wrapping from DIGITS-1 to 0.
REQ-021 anodes SHALL select the current digit index; segments SHALL show the hex-to-7-segment decode of that bcd digit (0..9); codes 10..15 SHALL display all segments off.

Reset
REQ-022 reset=0 at a rising edge SHALL force: FSM IDLE, busy 0, done 0, pending cleared, bcd 0, refresh counter 0, digit index 0.
REQ-023 After reset, anodes SHALL be all ones except bit 0 low, segments = 7'b1000000 ('0').
REQ-024 Reset mid-conversion SHALL abort it with no done pulse and bcd = 0.
REQ-025 valid during the reset cycle SHALL be ignored.

Configuration
REQ-026 Macro COUNT_DISP_BLANK_EN defined: leading zero digits above the most significant nonzero digit SHALL be blanked (segments 7'b1111111, anodes still scanned); digit 0 SHALL never be blanked.
REQ-027 Macro undefined: all DIGITS digits SHALL be displayed including leading zeros; no blanking logic present.

Verification (N=16, DIGITS=5, REFRESH_DIV=4)
REQ-028 Hold reset=0 2 cycles, release -> bcd=20'h00000, busy=0, done=0, anodes=5'b11110, segments=7'b1000000.
REQ-029 count=1234, valid 1 cycle -> busy high next cycle, done pulses 16 cycles after the capture edge, bcd=20'h01234.
REQ-030 count=65535, valid -> bcd=20'h65535; count=0, valid -> bcd=20'h00000, done pulses each time.
REQ-031 Capture 200; mid-conversion valid with 100 then 300 -> done with bcd=20'h00200, busy stays 1, next done with bcd=20'h00300, exactly two done pulses.
REQ-032 bcd=20'h00042, observe 20 cycles -> anodes rotate 11110, 11101, 11011, 10111, 01111 every 4 cycles; digits 2..4 show 7'b1111111 with COUNT_DISP_BLANK_EN, 7'b1000000 without.
REQ-033 reset=0 asserted 5 cycles into a conversion of 999 -> no done pulse, busy=0 next cycle, bcd=20'h00000.
